// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } ctrl_state_e;

  localparam logic [4:0] XZR_IDX   = 5'd31;
  localparam int         CNT_W_DEF = 16;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk) begin
    if (reset)                count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/bubble control for a 5-stage pipeline, with stage valid
// tracking and stall, flush and retirement counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rn,
  input  logic [4:0]       ifid_rm,
  input  logic             ifid_uses_rm,
  input  logic [4:0]       idex_rd,
  input  logic             idex_memtoreg,
  input  logic             idex_regwrite,
  input  logic             exmem_memaccess,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwr_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [3:0]       stage_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [31:0]      retired_cnt
);
  ctrl_state_e state, state_nxt;
  logic load_use, mem_wait;

  // XZR never carries a loaded value, so it cannot create a dependency.
  assign load_use = idex_memtoreg & idex_regwrite & (idex_rd != XZR_IDX) &
                    ((idex_rd == ifid_rn) | (ifid_uses_rm & (idex_rd == ifid_rm)));
  assign mem_wait = exmem_memaccess & ~dmem_ready & stage_valid[2];

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwr_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    state_nxt   = RUN;
    if (!reset) begin
      if (mem_wait) begin
        pc_en     = 1'b0;
        ifid_en   = 1'b0;
        idex_en   = 1'b0;
        exmem_en  = 1'b0;
        memwr_en  = 1'b0;
        state_nxt = MEM_WAIT;
      end else begin
        case (state)
          RUN: begin
            if (load_use) begin
              pc_en       = 1'b0;
              ifid_en     = 1'b0;
              idex_bubble = 1'b1;
              state_nxt   = LU_STALL;
            end else begin
              ifid_flush = branch_taken;
            end
          end
          // The branch in ID is re-evaluated once the load result is forwarded.
          LU_STALL: ifid_flush = branch_taken;
          default:  ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      stage_valid <= '0;
      retired_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (ifid_en)  stage_valid[0] <= ~ifid_flush;
      if (idex_en)  stage_valid[1] <= stage_valid[0] & ~idex_bubble;
      if (exmem_en) stage_valid[2] <= stage_valid[1];
      if (memwr_en) stage_valid[3] <= stage_valid[2];
      if (stage_valid[3] & memwr_en) retired_cnt <= retired_cnt + 32'd1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .reset(reset), .inc(~pc_en), .count(stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .reset(reset), .inc(ifid_flush), .count(flush_cnt)
  );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ifid_rn, ifid_rm, idex_rd;
  logic        ifid_uses_rm, idex_memtoreg, idex_regwrite;
  logic        exmem_memaccess, dmem_ready, branch_taken;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwr_en, ifid_flush, idex_bubble;
  logic [3:0]  stage_valid;
  logic [15:0] stall_cnt, flush_cnt;
  logic [31:0] retired_cnt;
  logic        sc_rst, sc_inc;
  logic [1:0]  sc_q;
  logic [6:0]  ctl;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .ifid_rn(ifid_rn), .ifid_rm(ifid_rm), .ifid_uses_rm(ifid_uses_rm),
    .idex_rd(idex_rd), .idex_memtoreg(idex_memtoreg), .idex_regwrite(idex_regwrite),
    .exmem_memaccess(exmem_memaccess), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwr_en(memwr_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .stage_valid(stage_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .retired_cnt(retired_cnt)
  );

  sat_counter #(.W(2)) u_sc (.clk(clk), .reset(sc_rst), .inc(sc_inc), .count(sc_q));

  // {pc, ifid, idex, exmem, memwr enables, ifid_flush, idex_bubble}
  assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwr_en, ifid_flush, idex_bubble};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    ifid_rn = 5'd0; ifid_rm = 5'd0; ifid_uses_rm = 1'b0;
    idex_rd = 5'd0; idex_memtoreg = 1'b0; idex_regwrite = 1'b0;
    exmem_memaccess = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rn);
    idex_rd = rd; ifid_rn = rn; idex_memtoreg = 1'b1; idex_regwrite = 1'b1;
  endtask

  initial begin
    idle();
    sc_rst = 1'b1; sc_inc = 1'b0;
    reset = 1'b1;
    exmem_memaccess = 1'b1; branch_taken = 1'b1;
    #1;
    chk("reset_ctl", 32'(ctl), 32'(7'b11111_00));
    tick(); tick();
    chk("reset_sv", 32'(stage_valid), 32'h0);
    chk("reset_stall", 32'(stall_cnt), 32'h0);
    chk("reset_flush", 32'(flush_cnt), 32'h0);
    chk("reset_ret", 32'(retired_cnt), 32'h0);

    // Independent instruction stream ramps valid bits then retires.
    idle();
    reset = 1'b0;
    tick(); chk("ramp1", 32'(stage_valid), 32'h1);
    tick(); chk("ramp2", 32'(stage_valid), 32'h3);
    tick(); chk("ramp3", 32'(stage_valid), 32'h7);
    tick(); chk("ramp4", 32'(stage_valid), 32'hf);
    for (int i = 0; i < 9; i++) tick();
    chk("ret9", retired_cnt, 32'd9);
    tick();
    chk("ret10", retired_cnt, 32'd10);

    // Load-use on Rn
    set_lu(5'd1, 5'd1);
    #1 chk("lu_ctl", 32'(ctl), 32'(7'b00111_01));
    tick();
    chk("lu_stall1", 32'(stall_cnt), 32'd1);
    chk("lu_sv", 32'(stage_valid), 32'hd);
    chk("lu_stall_state_ctl", 32'(ctl), 32'(7'b11111_00));
    tick();
    chk("lu_after_sv", 32'(stage_valid), 32'hb);
    chk("lu_after_stall", 32'(stall_cnt), 32'd1);

    // XZR destination and Rm gating
    set_lu(5'd31, 5'd31);
    #1 chk("xzr_ctl", 32'(ctl), 32'(7'b11111_00));
    set_lu(5'd5, 5'd0); ifid_rm = 5'd5;
    #1 chk("rm_unused_ctl", 32'(ctl), 32'(7'b11111_00));
    ifid_uses_rm = 1'b1;
    #1 chk("rm_used_ctl", 32'(ctl), 32'(7'b00111_01));
    idle();

    // Branch together with load-use: stall first, flush on re-evaluation
    set_lu(5'd2, 5'd2); branch_taken = 1'b1;
    #1 chk("br_lu_ctl", 32'(ctl), 32'(7'b00111_01));
    tick();
    chk("br_lu_stall", 32'(stall_cnt), 32'd2);
    chk("br_lu_flush0", 32'(flush_cnt), 32'd0);
    chk("br_lu_sv", 32'(stage_valid), 32'h5);
    chk("br_re_ctl", 32'(ctl), 32'(7'b11111_10));
    tick();
    chk("br_flush1", 32'(flush_cnt), 32'd1);
    chk("br_sv", 32'(stage_valid), 32'ha);
    idle();

    // Memory wait for three cycles, branch arriving mid-wait
    tick();
    chk("pre_mw_sv", 32'(stage_valid), 32'h5);
    exmem_memaccess = 1'b1;
    for (int i = 0; i < 3; i++) begin
      branch_taken = (i == 1);
      #1 chk("mw_ctl", 32'(ctl), 32'(7'b00000_00));
      tick();
      chk("mw_sv", 32'(stage_valid), 32'h5);
    end
    branch_taken = 1'b0;
    chk("mw_stall", 32'(stall_cnt), 32'd5);
    chk("mw_flush", 32'(flush_cnt), 32'd1);
    dmem_ready = 1'b1;
    #1 chk("mw_rel_ctl", 32'(ctl), 32'(7'b11111_00));
    tick();
    chk("mw_rel_sv", 32'(stage_valid), 32'hb);
    chk("mw_rel_stall", 32'(stall_cnt), 32'd5);
    idle();

    // Reset pulse during MEM_WAIT
    tick();
    chk("pre_rst_sv", 32'(stage_valid), 32'h7);
    exmem_memaccess = 1'b1;
    tick();
    chk("rmw_sv", 32'(stage_valid), 32'h7);
    chk("rmw_stall", 32'(stall_cnt), 32'd6);
    reset = 1'b1;
    #1 chk("rmw_rst_ctl", 32'(ctl), 32'(7'b11111_00));
    tick();
    chk("rmw_sv0", 32'(stage_valid), 32'h0);
    chk("rmw_stall0", 32'(stall_cnt), 32'h0);
    chk("rmw_flush0", 32'(flush_cnt), 32'h0);
    chk("rmw_ret0", retired_cnt, 32'h0);
    reset = 1'b0;
    set_lu(5'd3, 5'd3);
    #1 chk("rmw_run_ctl", 32'(ctl), 32'(7'b00111_01));
    idle();

    // Saturation boundary on a narrow counter
    tick();
    sc_rst = 1'b0; sc_inc = 1'b1;
    tick(); tick();
    chk("sat_2", 32'(sc_q), 32'd2);
    tick(); tick(); tick();
    chk("sat_hold", 32'(sc_q), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
